// File: rtl/ws2812b_strip_driver.sv
// WS2812B strip driver: NUM_LEDS x 24-bit frame buffer, per-frame brightness scaling,
// GRB serialiser with back-to-back bit periods and a trailing latch gap.
module ws2812b_strip_driver #(
    parameter int NUM_LEDS = 64,
    parameter int ADDR_W   = 6,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63,
    parameter int TRST_CYC = 3000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [7:0]        brightness,
    input  logic              start,
    input  logic              auto_refresh,
    output logic              busy,
    output logic              frame_done,
    output logic              dout
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int TIMER_W = $clog2(TBIT_CYC);
    localparam int LATCH_W = (TRST_CYC > 2) ? $clog2(TRST_CYC) : 1;

    localparam logic [ADDR_W:0]    LED_COUNT  = (ADDR_W+1)'(NUM_LEDS);
    localparam logic [ADDR_W-1:0]  LAST_LED   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W-1:0]  LED_ONE    = ADDR_W'(1);
    localparam logic [TIMER_W-1:0] LAST_TICK  = TIMER_W'(TBIT_CYC - 1);
    localparam logic [TIMER_W-1:0] TICK_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] T0H_TICKS  = TIMER_W'(T0H_CYC);
    localparam logic [TIMER_W-1:0] T1H_TICKS  = TIMER_W'(T1H_CYC);
    localparam logic [LATCH_W-1:0] LAST_LATCH = LATCH_W'(TRST_CYC - 2);
    localparam logic [LATCH_W-1:0] LATCH_ONE  = LATCH_W'(1);
    localparam logic [4:0]         LAST_BIT   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // c' = (c * (brightness + 1)) >> 8; the product never exceeds 16 bits
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
        return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
    endfunction

    function automatic logic [23:0] to_grb(input logic [23:0] rgb, input logic [7:0] b);
        return {scale_chan(rgb[15:8], b), scale_chan(rgb[23:16], b), scale_chan(rgb[7:0], b)};
    endfunction

    logic [23:0]        mem_r [DEPTH];
    state_t             state_r, state_s;
    logic [TIMER_W-1:0] timer_r, timer_s;
    logic [4:0]         bit_r, bit_s;
    logic [ADDR_W-1:0]  led_r, led_s;
    logic [ADDR_W-1:0]  fetch_idx_s;
    logic [23:0]        shift_r, shift_s;
    logic [23:0]        fetch_s;
    logic [LATCH_W-1:0] latch_r, latch_s;
    logic [7:0]         bright_r, bright_s;
    logic               dout_r, dout_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    // Frame buffer; indices at or beyond NUM_LEDS are never written and stay zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 24'h000000;
            end
        end else if (wr_en && ({1'b0, wr_addr} < LED_COUNT)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Next-state, counters and next values of the registered outputs
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        bit_s       = bit_r;
        led_s       = led_r;
        shift_s     = shift_r;
        latch_s     = latch_r;
        bright_s    = bright_r;
        done_s      = 1'b0;
        busy_s      = 1'b0;
        dout_s      = 1'b0;
        fetch_idx_s = led_r;

        // LOAD reads the first pixel; during SEND the next LED is prefetched
        if (state_r == ST_LOAD) begin
            fetch_idx_s = led_r;
        end else begin
            fetch_idx_s = led_r + LED_ONE;
        end
        fetch_s = to_grb(mem_r[fetch_idx_s], bright_r);

        case (state_r)
            ST_IDLE: begin
                // busy_r is only high here in the frame_done cycle, where start is ignored
                if (auto_refresh || (start && !busy_r)) begin
                    state_s  = ST_LOAD;
                    led_s    = {ADDR_W{1'b0}};
                    bright_s = brightness;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shift_s = fetch_s;
                timer_s = {TIMER_W{1'b0}};
                bit_s   = 5'd0;
                state_s = ST_SEND;
            end
            ST_SEND: begin
                if (timer_r == LAST_TICK) begin
                    timer_s = {TIMER_W{1'b0}};
                    if (bit_r == LAST_BIT) begin
                        bit_s = 5'd0;
                        if (led_r == LAST_LED) begin
                            state_s = ST_LATCH;
                            latch_s = {LATCH_W{1'b0}};
                        end else begin
                            led_s   = led_r + LED_ONE;
                            shift_s = fetch_s;
                        end
                    end else begin
                        bit_s   = bit_r + 5'd1;
                        shift_s = {shift_r[22:0], 1'b0};
                    end
                end else begin
                    timer_s = timer_r + TICK_ONE;
                end
            end
            ST_LATCH: begin
                // The frame_done cycle itself is the last low cycle of the gap
                if (latch_r == LAST_LATCH) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    latch_s = latch_r + LATCH_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE) || done_s;
        if (state_s == ST_SEND) begin
            dout_s = timer_s < (shift_s[23] ? T1H_TICKS : T0H_TICKS);
        end else begin
            dout_s = 1'b0;
        end
    end

    // State, counters and output registers; reset aborts a frame immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            timer_r  <= {TIMER_W{1'b0}};
            bit_r    <= 5'd0;
            led_r    <= {ADDR_W{1'b0}};
            shift_r  <= 24'h000000;
            latch_r  <= {LATCH_W{1'b0}};
            bright_r <= 8'd0;
            dout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            bit_r    <= bit_s;
            led_r    <= led_s;
            shift_r  <= shift_s;
            latch_r  <= latch_s;
            bright_r <= bright_s;
            dout_r   <= dout_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign dout       = dout_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule
